// File: rtl/vsd_quant_pkg.sv
// vsd_quant_pkg: shared widths, unity scale, signed typedefs and saturating clamp
package vsd_quant_pkg;
  localparam int PARAM_BIT = 8;
  localparam int PARTIAL_BIT = 25;
  localparam int SCALE_BIT = 16;
  localparam int DSHIFT = 8;
  localparam logic signed [SCALE_BIT-1:0] UNITY_SCALE = SCALE_BIT'(1 << DSHIFT);
  typedef logic signed [PARAM_BIT-1:0] act_t;
  typedef logic signed [PARTIAL_BIT-1:0] psum_t;
  typedef logic signed [SCALE_BIT-1:0] scale_t;
  typedef logic signed [63:0] wide_t;
  function automatic wide_t sat(input wide_t v, input int w);
    wide_t hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return v > hi ? hi : v < lo ? lo : v;
  endfunction
endpackage

// File: rtl/dequant_scale_mem.sv
// dequant_scale_mem: CH x SCALE_BIT scale table, one write port, one registered read port
// Ports: clk, rst (async, active-high, table -> unity), we/waddr/wdata write,
// re/raddr read enable and index, rdata registered read (old value on same-cycle write).
module dequant_scale_mem
  import vsd_quant_pkg::*;
#(
  parameter int CH = 16,
  parameter int SCALE_BIT = vsd_quant_pkg::SCALE_BIT,
  parameter int DSHIFT = vsd_quant_pkg::DSHIFT,
  localparam int CH_W = $clog2(CH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        we,
  input  logic [CH_W-1:0]             waddr,
  input  logic signed [SCALE_BIT-1:0] wdata,
  input  logic                        re,
  input  logic [CH_W-1:0]             raddr,
  output logic signed [SCALE_BIT-1:0] rdata
);
  localparam logic signed [SCALE_BIT-1:0] UNITY = SCALE_BIT'(1 << DSHIFT);
  logic signed [SCALE_BIT-1:0] mem [CH];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < CH; i++) mem[i] <= UNITY;
      rdata <= UNITY;
    end else begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/act_dequant.sv
// act_dequant: int8 activation -> partial-sum dequantizer, sat((act*scale[ch]) >>> DSHIFT)
// Ports: clk, rst (async, active-high), scale_we/scale_waddr/scale_wdata table write,
// in_valid/in_ready/act_in/in_last input stream, out_valid/out_ready/psum_out/out_last output.
// Option: define DEQUANT_ROUND_EN to round half toward +inf instead of floor.
module act_dequant
  import vsd_quant_pkg::*;
#(
  parameter int PARAM_BIT = vsd_quant_pkg::PARAM_BIT,
  parameter int PARTIAL_BIT = vsd_quant_pkg::PARTIAL_BIT,
  parameter int SCALE_BIT = vsd_quant_pkg::SCALE_BIT,
  parameter int DSHIFT = vsd_quant_pkg::DSHIFT,
  parameter int CH = 16,
  localparam int CH_W = $clog2(CH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          scale_we,
  input  logic [CH_W-1:0]               scale_waddr,
  input  logic signed [SCALE_BIT-1:0]   scale_wdata,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [PARAM_BIT-1:0]   act_in,
  input  logic                          in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [PARTIAL_BIT-1:0] psum_out,
  output logic                          out_last
);
  logic s1_v, s1_last, s2_adv, accept;
  logic signed [PARAM_BIT-1:0] s1_act;
  logic signed [SCALE_BIT-1:0] s1_scale;
  logic [CH_W-1:0] ch;
  wide_t prod, shifted;
  assign s2_adv = !out_valid || out_ready;
  assign in_ready = !s1_v || s2_adv;
  assign accept = in_valid && in_ready;
  // the table read is registered alongside act_in so both land in stage 1 together
  dequant_scale_mem #(.CH(CH), .SCALE_BIT(SCALE_BIT), .DSHIFT(DSHIFT)) u_mem (
    .clk(clk), .rst(rst), .we(scale_we), .waddr(scale_waddr), .wdata(scale_wdata),
    .re(accept), .raddr(ch), .rdata(s1_scale)
  );
  always_comb begin
    prod = 64'(s1_act) * 64'(s1_scale);
`ifdef DEQUANT_ROUND_EN
    shifted = (prod + (64'sd1 <<< (DSHIFT - 1))) >>> DSHIFT;
`else
    shifted = prod >>> DSHIFT;
`endif
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ch <= '0;
      s1_v <= 1'b0;
      s1_act <= '0;
      s1_last <= 1'b0;
      out_valid <= 1'b0;
      psum_out <= '0;
      out_last <= 1'b0;
    end else begin
      if (accept) ch <= (in_last || ch == CH_W'(CH - 1)) ? '0 : ch + 1'b1;
      if (in_ready) s1_v <= in_valid;
      if (accept) begin
        s1_act <= act_in;
        s1_last <= in_last;
      end
      if (s2_adv) out_valid <= s1_v;
      if (s2_adv && s1_v) begin
        psum_out <= PARTIAL_BIT'(sat(shifted, PARTIAL_BIT));
        out_last <= s1_last;
      end
    end
endmodule

// File: tb/tb_act_dequant.sv
// tb_act_dequant: directed self-checking bench for act_dequant
module tb_act_dequant;
  logic clk = 0, rst = 1;
  logic scale_we = 0;
  logic [3:0] scale_waddr = '0;
  logic signed [15:0] scale_wdata = '0;
  logic in_valid = 0, in_ready, in_last = 0, out_valid, out_ready = 1, out_last;
  logic signed [7:0] act_in = '0;
  logic signed [24:0] psum_out;
  logic b_we = 0, b_in_valid = 0, b_in_ready, b_last = 0, b_out_valid, b_out_last;
  logic [3:0] b_waddr = '0;
  logic signed [15:0] b_wdata = '0;
  logic signed [7:0] b_act = '0;
  logic signed [11:0] b_psum;
  int n_chk = 0, n_err = 0, n_got = 0, base;
  longint got_p [256];
  logic got_l [256];
  longint held;
`ifdef DEQUANT_ROUND_EN
  localparam bit RND = 1;
`else
  localparam bit RND = 0;
`endif
  localparam longint EXP4 [10] = '{1, 2, 3, 6, 5, 6, 7, 8, 9, 10};
  always #5 clk = ~clk;
  act_dequant dut (
    .clk(clk), .rst(rst), .scale_we(scale_we), .scale_waddr(scale_waddr),
    .scale_wdata(scale_wdata), .in_valid(in_valid), .in_ready(in_ready), .act_in(act_in),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .psum_out(psum_out),
    .out_last(out_last)
  );
  act_dequant #(.PARTIAL_BIT(12)) dut12 (
    .clk(clk), .rst(rst), .scale_we(b_we), .scale_waddr(b_waddr), .scale_wdata(b_wdata),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .act_in(b_act), .in_last(b_last),
    .out_valid(b_out_valid), .out_ready(1'b1), .psum_out(b_psum), .out_last(b_out_last)
  );
  always @(negedge clk)
    if (!rst && out_valid && out_ready) begin
      got_p[n_got] = psum_out;
      got_l[n_got] = out_last;
      n_got++;
    end
  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic wscale(input logic [3:0] a, input logic [15:0] d);
    scale_we = 1; scale_waddr = a; scale_wdata = d;
    cyc();
    scale_we = 0;
  endtask
  task automatic send(input logic signed [7:0] a, input logic l);
    int t = 0;
    logic ok = 0;
    in_valid = 1; act_in = a; in_last = l;
    while (!ok && t < 50) begin
      @(negedge clk);
      ok = in_ready;
      cyc();
      t++;
    end
    in_valid = 0; in_last = 0;
    chk("send_accepted", longint'(ok), 1);
  endtask
  initial begin
    #3;
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_psum", psum_out, 0);
    chk("rst_out_last", longint'(out_last), 0);
    cyc();
    rst = 0;
    cyc();
    chk("post_rst_in_ready", longint'(in_ready), 1);
    // unity scale, back-to-back, latency
    send(-8'sd5, 0);
    send(8'sd127, 1);
    chk("lat_first", psum_out, -5);
    chk("lat_first_valid", longint'(out_valid), 1);
    cyc();
    chk("lat_second", psum_out, 127);
    chk("lat_second_last", longint'(out_last), 1);
    // scale 1.5 on channel 3, floor vs round on +/-10.5
    wscale(4'd3, 16'h0180);
    base = n_got;
    for (int i = 0; i < 4; i++) send(8'sd7, i == 3);
    for (int i = 0; i < 4; i++) send(i == 3 ? -8'sd7 : 8'sd0, i == 3);
    repeat (3) cyc();
    chk("s3_count", n_got - base, 8);
    chk("s3_ch0", got_p[base], 7);
    chk("s3_pos", got_p[base+3], RND ? 11 : 10);
    chk("s3_neg", got_p[base+7], RND ? -10 : -11);
    chk("s3_last", longint'(got_l[base+3]), 1);
    // stall: output held, input backpressured, order preserved
    base = n_got;
    fork
      for (int i = 1; i <= 10; i++) send(8'(i), i == 10);
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 0;
        cyc();
        held = psum_out;
        repeat (4) begin
          cyc();
          chk("stall_stable", psum_out, held);
          chk("stall_valid", longint'(out_valid), 1);
        end
        chk("stall_in_ready", longint'(in_ready), 0);
        out_ready = 1;
      end
    join
    repeat (4) cyc();
    chk("stall_count", n_got - base, 10);
    for (int i = 0; i < 10; i++) chk("stall_order", got_p[base+i], EXP4[i]);
    chk("stall_last", longint'(got_l[base+9]), 1);
    // channel wrap after 16 beats and in_last reset of the counter
    wscale(4'd0, 16'h0200);
    base = n_got;
    for (int i = 0; i < 17; i++) send(8'sd3, 0);
    repeat (3) cyc();
    chk("wrap_count", n_got - base, 17);
    chk("wrap_b1", got_p[base], 6);
    chk("wrap_b2", got_p[base+1], 3);
    chk("wrap_b4", got_p[base+3], RND ? 5 : 4);
    chk("wrap_b17", got_p[base+16], 6);
    base = n_got;
    for (int i = 1; i <= 6; i++) send(8'sd3, i == 5);
    repeat (3) cyc();
    chk("vec_b3", got_p[base+2], RND ? 5 : 4);
    chk("vec_b5_last", longint'(got_l[base+4]), 1);
    chk("vec_b6", got_p[base+5], 6);
    chk("vec_b6_last", longint'(got_l[base+5]), 0);
    // asynchronous reset mid-stream
    out_ready = 0;
    send(8'sd3, 0);
    send(8'sd3, 0);
    #2 rst = 1;
    #1;
    chk("mid_rst_valid", longint'(out_valid), 0);
    chk("mid_rst_psum", psum_out, 0);
    cyc();
    rst = 0;
    out_ready = 1;
    cyc();
    chk("mid_rst_in_ready", longint'(in_ready), 1);
    base = n_got;
    send(8'sd9, 0);
    wscale(4'd1, 16'h0200);
    send(8'sd9, 0);
    repeat (3) cyc();
    chk("mid_rst_count", n_got - base, 2);
    chk("mid_rst_unity", got_p[base], 9);
    chk("mid_rst_ch1", got_p[base+1], 18);
    // clamp with a 12-bit partial sum
    b_we = 1; b_waddr = 0; b_wdata = 16'h7FFF;
    cyc();
    b_we = 0; b_in_valid = 1; b_act = 8'sd127; b_last = 1;
    cyc();
    b_act = -8'sd128; b_last = 0;
    cyc();
    b_in_valid = 0;
    chk("clamp_pos", b_psum, 2047);
    chk("clamp_pos_valid", longint'(b_out_valid), 1);
    cyc();
    chk("clamp_neg", b_psum, -2048);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
